// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_pkg
// Purpose  : Shared MD instruction constants: op field width, op codes and
//            small classification helpers used by the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

    // Width of the MD op field
    localparam int c_MD_OP_W = 4;

    localparam logic [c_MD_OP_W-1:0] c_MD_OP_NONE  = 4'd0;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MULT  = 4'd1;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MULTU = 4'd2;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_DIV   = 4'd3;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_DIVU  = 4'd4;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MADD  = 4'd5;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MADDU = 4'd6;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MSUB  = 4'd7;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MSUBU = 4'd8;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MTHI  = 4'd9;
    localparam logic [c_MD_OP_W-1:0] c_MD_OP_MTLO  = 4'd10;

    // True for ops that occupy the unit for a multi-cycle latency
    function automatic logic md_is_arith(input logic [c_MD_OP_W-1:0] op);
        return (op >= c_MD_OP_MULT) && (op <= c_MD_OP_MSUBU);
    endfunction

    // True for ops that use the divide latency class
    function automatic logic md_is_div(input logic [c_MD_OP_W-1:0] op);
        return (op == c_MD_OP_DIV) || (op == c_MD_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
// Module   : md_calc
// Purpose  : Combinational arithmetic for the MD unit. Produces the pending
//            {phi,plo} result for multiply, multiply-accumulate and divide,
//            including divide-by-zero and signed-overflow corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module md_calc
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [c_MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]     rs,
    input  logic [WIDTH-1:0]     rt,
    input  logic [WIDTH-1:0]     hi,
    input  logic [WIDTH-1:0]     lo,
    output logic [WIDTH-1:0]     phi,
    output logic [WIDTH-1:0]     plo
);

    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_uprod;
    logic [2*WIDTH-1:0] w_acc;
    logic               w_signed_div;
    logic               w_rt_zero;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Full-width products: operands are sign/zero extended so the product is exact mod 2^(2W)
    assign w_sprod = $signed({{WIDTH{rs[WIDTH-1]}}, rs}) * $signed({{WIDTH{rt[WIDTH-1]}}, rt});
    assign w_uprod = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
    assign w_acc   = {hi, lo};

    assign w_signed_div = (op == c_MD_OP_DIV);
    assign w_rt_zero    = (rt == '0);

    // Divide on magnitudes, then restore signs; MIN/-1 falls out naturally as MIN rem 0
    always_comb begin
        w_dvd = (w_signed_div && rs[WIDTH-1]) ? -rs : rs;
        w_dvs = (w_signed_div && rt[WIDTH-1]) ? -rt : rt;
        // Keep the divider free of X when the divisor is zero; that result is overridden
        if (w_rt_zero) begin
            w_dvs = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        w_uq   = w_dvd / w_dvs;
        w_ur   = w_dvd % w_dvs;
        w_quot = (w_signed_div && (rs[WIDTH-1] ^ rt[WIDTH-1])) ? -w_uq : w_uq;
        w_rem  = (w_signed_div && rs[WIDTH-1]) ? -w_ur : w_ur;
    end

    // Result selection per op; undefined ops leave the accumulator value unchanged
    always_comb begin
        {phi, plo} = w_acc;
        case (op)
            c_MD_OP_MULT:  {phi, plo} = w_sprod;
            c_MD_OP_MULTU: {phi, plo} = w_uprod;
            c_MD_OP_MADD:  {phi, plo} = w_acc + w_sprod;
            c_MD_OP_MADDU: {phi, plo} = w_acc + w_uprod;
            c_MD_OP_MSUB:  {phi, plo} = w_acc - w_sprod;
            c_MD_OP_MSUBU: {phi, plo} = w_acc - w_uprod;
            c_MD_OP_DIV,
            c_MD_OP_DIVU: begin
                if (w_rt_zero) begin
                    phi = rs;
                    plo = '1;
                end else begin
                    phi = w_rem;
                    plo = w_quot;
                end
            end
            default: {phi, plo} = w_acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit owning the HI/LO pair. Holds
//            the IDLE/RUN control, latency down-counter, pending result and
//            architectural HI/LO registers; arithmetic lives in md_calc.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [c_MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]     rs,
    input  logic [WIDTH-1:0]     rt,
    input  logic                 cancel,
    output logic                 busy,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic               r_busy,  w_busy_nxt;
    logic [WIDTH-1:0]   r_phi,   w_phi_nxt;
    logic [WIDTH-1:0]   r_plo,   w_plo_nxt;
    logic [WIDTH-1:0]   r_hi,    w_hi_nxt;
    logic [WIDTH-1:0]   r_lo,    w_lo_nxt;
    logic [WIDTH-1:0]   w_calc_hi;
    logic [WIDTH-1:0]   w_calc_lo;

    // Accumulating ops see the architectural HI/LO as they stand at accept
    md_calc #(
        .WIDTH (WIDTH)
    ) u_md_calc (
        .op  (op),
        .rs  (rs),
        .rt  (rt),
        .hi  (r_hi),
        .lo  (r_lo),
        .phi (w_calc_hi),
        .plo (w_calc_lo)
    );

    // State, counter, pending and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in RUN, commit or discard on exit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            c_ST_IDLE: begin
                // cancel in the same cycle as start suppresses the op entirely
                if (start && !cancel) begin
                    if (md_is_arith(op)) begin
                        w_state_nxt = c_ST_RUN;
                        w_cnt_nxt   = md_is_div(op) ? c_CNT_DIV : c_CNT_MULT;
                        w_phi_nxt   = w_calc_hi;
                        w_plo_nxt   = w_calc_lo;
                    end else if (op == c_MD_OP_MTHI) begin
                        w_hi_nxt = rs;
                    end else if (op == c_MD_OP_MTLO) begin
                        w_lo_nxt = rs;
                    end
                end
            end
            c_ST_RUN: begin
                // start is deliberately ignored here; the hazard unit stalls it
                if (cancel) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = r_phi;
                    w_lo_nxt    = r_plo;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == c_ST_RUN);
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the EX stage of the 5-stage pipeline. It accepts one operation per start pulse, models a fixed configurable latency per class (multiply/divide), and supports accumulate, subtract-accumulate, direct HI/LO writes and cancellation on pipeline flush. It drives the busy flag that the hazard unit uses to stall HI/LO reads and further MD instructions in ID.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  accept op this cycle (ignored if busy or cancel)
- op  in  4  MD operation code (shared constants)
- rs  in  WIDTH  operand A / dividend / MTHI-MTLO data
- rt  in  WIDTH  operand B / divisor
- cancel  in  1  abort in-flight op (EX flush)
- busy  out  1  registered; high while an op is in flight
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

## Operation
- States: IDLE, RUN. Down-counter cnt, width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE + start + !cancel:
  - MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU: compute result into pending {phi,plo}, load cnt with class latency, go RUN.
  - MTHI/MTLO: write hi/lo at that edge; stay IDLE, busy stays 0.
  - NONE or undefined op: no effect.
- RUN: cnt decrements each cycle; when cnt reaches 1, the next edge commits {phi,plo} to {hi,lo}, clears busy, and returns to IDLE.
- RUN + cancel: next edge → IDLE, busy 0, hi/lo unchanged, pending discarded.
- start while busy: ignored (hazard unit guarantees stall; bench checks no effect).
- cancel and start in the same IDLE cycle: cancel wins, op ignored.
- Arithmetic:
  - MULT/MULTU → 2·WIDTH signed/unsigned product; {hi,lo} = product.
  - MADD(U)/MSUB(U): {hi,lo} ± product, using hi/lo at accept, modulo 2^(2·WIDTH).
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder with sign of dividend.
  - Divide by zero (both): lo = all ones, hi = rs.
  - DIV of MIN / −1: lo = MIN, hi = 0.
- hi/lo never change except on commit, MTHI/MTLO, or reset.

## Timing
- Reset (async, immediate): busy=0, hi=0, lo=0, cnt=0, state IDLE. Reset mid-op drops the op.
- Accept at edge E0: busy=1 from E0 through E0+N−1, where N is the class latency. At edge E0+N, new hi/lo are visible and busy=0.
- A new start is accepted in the same cycle busy is 0 after commit. Back-to-back throughput is one op per N+1 cycles, including the accept cycle.
- MTHI/MTLO latency: 1 edge; readable the next cycle.
- Outputs are fully registered; there is no combinational path from inputs to busy/hi/lo.

## Structure
- Shared instruction header holds MD_OP codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10. It also holds the width macro for the op field (4).
- One combinational sub-module, md_calc (op, rs, rt, hi, lo → phi, plo), implements all arithmetic and corner cases. md_unit holds the FSM, counter, pending and architectural registers.

## Test plan
WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10 throughout.
- MULT rs=0xFFFFFFFD, rt=7 → busy exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU same operands → hi=0x00000006, lo=0xFFFFFFEB.
- DIVU 100/7 → after 10 cycles lo=14, hi=2. DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0 then MTLO 10 (busy stays 0, each visible next cycle). MADDU 3·4 → {0,22}. MSUB 1·23 → {0xFFFFFFFF,0xFFFFFFFF}.
- DIV started with hi=lo=0x55 and cancel asserted in the 3rd busy cycle → busy 0 next edge, hi=lo=0x55. A start pulse with MULT while busy → no effect on result or timing.
- reset asserted asynchronously mid-MULT → busy, hi and lo go to 0 before the next clock edge. After release, the unit accepts a new op normally.
